// File: rtl/mem_responder_if.sv
// Request/response bus between the multicycle core and mem_responder.
// master = requester (core side), slave = memory responder.
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ready;
  logic        err;
  logic [31:0] io_out;

  modport master (
    output req, we, a, wd,
    input  rd, ready, err, io_out
  );

  modport slave (
    input  req, we, a, wd,
    output rd, ready, err, io_out
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM behind a wait-state FSM with a
// one-cycle ready strobe and error flagging for misaligned/out-of-range
// accesses.
// Optional MMIO (cycle counter at 0xFFFF_FFF0, io_out at 0xFFFF_FFF4) is
// built only when MEM_RESP_MMIO_EN is defined.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for req; request fields captured on acceptance
// BUSY  | burning wait states, counter counts down to 1
// DONE  | ready strobe; RAM/MMIO commit happened on the edge into here
module mem_responder #(
  parameter int DEPTH       = 64,
  parameter int ADDR_BITS   = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0]         WAIT_L  = 4'(WAIT_CYCLES);
  localparam logic [ADDR_BITS:0] DEPTH_L = (ADDR_BITS + 1)'(DEPTH);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        we_q;
  logic [31:0] a_q, wd_q;
  logic [31:0] rd_q;
  logic        err_q;
  logic [31:0] ram [DEPTH];

  logic                 cur_we;
  logic [31:0]          cur_a, cur_wd;
  logic [ADDR_BITS-1:0] idx;
  logic                 in_range, aligned;
  logic                 hit_cyc, hit_io, mmio_hit, acc_err, enter_done;
  logic [31:0]          cyc_val, io_val, rd_src;

  // With WAIT_CYCLES = 0 the commit edge is the acceptance edge itself, so
  // the decode must look at the live bus while still in IDLE.
  assign cur_we = (state == IDLE) ? bus.we : we_q;
  assign cur_a  = (state == IDLE) ? bus.a  : a_q;
  assign cur_wd = (state == IDLE) ? bus.wd : wd_q;

  assign idx      = cur_a[ADDR_BITS+1:2];
  assign aligned  = (cur_a[1:0] == 2'b00);
  assign in_range = (cur_a[31:ADDR_BITS+2] == '0) && ({1'b0, idx} < DEPTH_L);

`ifdef MEM_RESP_MMIO_EN
  logic [31:0] cyc_q, io_q;

  assign hit_cyc = (cur_a == 32'hFFFF_FFF0);
  assign hit_io  = (cur_a == 32'hFFFF_FFF4);
  assign cyc_val = cyc_q;
  assign io_val  = io_q;

  // Free-running cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_q + 32'd1;
  end

  // io_out register, loaded by a write to its address on DONE entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                io_q <= '0;
    else if (enter_done && cur_we && hit_io)  io_q <= cur_wd;
  end

  assign bus.io_out = io_q;
`else
  assign hit_cyc    = 1'b0;
  assign hit_io     = 1'b0;
  assign cyc_val    = '0;
  assign io_val     = '0;
  assign bus.io_out = '0;
`endif

  assign mmio_hit   = hit_cyc || hit_io;
  assign acc_err    = !mmio_hit && !(aligned && in_range);
  assign enter_done = (state_nxt == DONE) && (state != DONE);
  assign rd_src     = hit_cyc ? cyc_val : (hit_io ? io_val : ram[idx]);

  // State and wait counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; req is only looked at in IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.req) begin
          cnt_nxt   = WAIT_L;
          state_nxt = (WAIT_L == 4'd0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request fields on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q <= 1'b0;
      a_q  <= '0;
      wd_q <= '0;
    end else if (state == IDLE && bus.req) begin
      we_q <= bus.we;
      a_q  <= bus.a;
      wd_q <= bus.wd;
    end
  end

  // Response data and error flag, updated on DONE entry; err drops on exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      err_q <= 1'b0;
    end else if (enter_done) begin
      err_q <= acc_err;
      rd_q  <= (acc_err || cur_we) ? 32'd0 : rd_src;
    end else if (state == DONE) begin
      err_q <= 1'b0;
    end
  end

  // RAM write port; held off during reset so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (!reset && enter_done && cur_we && !acc_err && !mmio_hit)
      ram[idx] <= cur_wd;
  end

  assign bus.rd    = rd_q;
  assign bus.err   = err_q;
  assign bus.ready = (state == DONE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with 2 wait states (main random
// run) and one with 0 wait states, sharing stimulus through a select.
module tb_mem_responder;

`ifdef MEM_RESP_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b1;          // 1 = WAIT_CYCLES 2 instance, 0 = WAIT_CYCLES 0
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] wd = '0;

  int total = 0;
  int fails = 0;

  logic [31:0] mem2 [64];
  logic [31:0] mem0 [64];
  logic [31:0] io_m = '0;

  mem_responder_if i2 ();
  mem_responder_if i0 ();

  assign i2.req = req & sel;
  assign i2.we  = we;
  assign i2.a   = a;
  assign i2.wd  = wd;
  assign i0.req = req & ~sel;
  assign i0.we  = we;
  assign i0.a   = a;
  assign i0.wd  = wd;

  mem_responder #(.DEPTH(64), .ADDR_BITS(6), .WAIT_CYCLES(2)) u2 (
    .clk(clk), .reset(reset), .bus(i2.slave)
  );
  mem_responder #(.DEPTH(64), .ADDR_BITS(6), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset), .bus(i0.slave)
  );

  wire [31:0] rd_s    = sel ? i2.rd     : i0.rd;
  wire        ready_s = sel ? i2.ready  : i0.ready;
  wire        err_s   = sel ? i2.err    : i0.err;
  wire [31:0] io_s    = sel ? i2.io_out : i0.io_out;

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one transaction and checks the ready strobe lands exactly after
  // the instance's wait states; returns the response sampled in DONE.
  task automatic txn(input logic w, input logic [31:0] addr, input logic [31:0] data,
                     input string tag, output logic [31:0] rdo, output logic erro,
                     output logic [31:0] ioo);
    int lat;
    lat = sel ? 2 : 0;
    @(negedge clk);
    chk({tag, "/idle_ready"}, {31'b0, ready_s}, 32'd0);
    req = 1'b1; we = w; a = addr; wd = data;
    @(posedge clk);
    #1 req = 1'b0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk({tag, "/wait_ready"}, {31'b0, ready_s}, 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    chk({tag, "/ready"}, {31'b0, ready_s}, 32'd1);
    rdo  = rd_s;
    erro = err_s;
    ioo  = io_s;
  endtask

  // Reference: a word memory of 64 entries at byte addresses 0..255, with
  // the MMIO register at 0xFFFF_FFF4 when enabled.
  task automatic run(input logic w, input logic [31:0] addr, input logic [31:0] data,
                     input string tag);
    logic [31:0] erd, grd, gio;
    logic        eerr, gerr, mmio_io;
    int          widx;
    mmio_io = MMIO && (addr == 32'hFFFF_FFF4);
    eerr    = !mmio_io && !((addr % 4 == 0) && (addr < 64 * 4));
    widx    = int'(addr / 4) % 64;
    if (eerr || w)    erd = 32'd0;
    else if (mmio_io) erd = io_m;
    else              erd = sel ? mem2[widx] : mem0[widx];
    txn(w, addr, data, tag, grd, gerr, gio);
    chk({tag, "/err"}, {31'b0, gerr}, {31'b0, eerr});
    chk({tag, "/rd"}, grd, erd);
    if (w && !eerr) begin
      if (mmio_io) io_m = data;
      else if (sel) mem2[widx] = data;
      else mem0[widx] = data;
    end
    if (sel) chk({tag, "/io_out"}, gio, io_m);
  endtask

  initial begin
    logic [31:0] addr, data, c1, c2, tmp;
    logic        e;
    int          kind;

    repeat (3) @(negedge clk);
    chk("rst/ready2", {31'b0, i2.ready}, 32'd0);
    chk("rst/err2",   {31'b0, i2.err},   32'd0);
    chk("rst/rd2",    i2.rd,             32'd0);
    chk("rst/io2",    i2.io_out,         32'd0);
    chk("rst/ready0", {31'b0, i0.ready}, 32'd0);
    chk("rst/rd0",    i0.rd,             32'd0);
    reset = 1'b0;

    sel = 1'b1;
    for (int i = 0; i < 64; i++) run(1'b1, 32'(i * 4), $urandom, "fill");

    run(1'b1, 32'h10, 32'hDEAD_BEEF, "t1_wr");
    run(1'b0, 32'h10, 32'h0, "t1_rd");

    run(1'b1, 32'h6, 32'hFFFF_FFFF, "t3_miswr");
    run(1'b0, 32'h4, 32'h0, "t3_rd4");

    run(1'b0, 32'h100, 32'h0, "t4_oor");
    run(1'b0, 32'h8, 32'h0, "t4_next");

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      data = $urandom;
      if (kind == 0)      addr = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
      else if (kind == 1) addr = 32'h100 + 32'($urandom_range(0, 4000)) * 4;
      else                addr = 32'($urandom_range(0, 63)) * 4;
      run(1'($urandom_range(0, 1)), addr, data, "rand");
    end

    // reset during BUSY of a write: no strobe, outputs cleared, no commit
    run(1'b0, 32'h24, 32'h0, "t5_pre");
    @(negedge clk);
    req = 1'b1; we = 1'b1; a = 32'h20; wd = 32'hCAFE_0001;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t5/ready", {31'b0, i2.ready}, 32'd0);
    chk("t5/rd",    i2.rd,             32'd0);
    chk("t5/err",   {31'b0, i2.err},   32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("t5/ready_hold", {31'b0, i2.ready}, 32'd0);
    end
    chk("t5/io", i2.io_out, 32'd0);
    io_m = '0;
    reset = 1'b0;
    run(1'b0, 32'h20, 32'h0, "t5_rd20");

    sel = 1'b0;
    run(1'b1, 32'h0, 32'h1234_5678, "t2_wr");
    run(1'b0, 32'h0, 32'h0, "t2_rd");
    run(1'b1, 32'hFC, 32'h0BAD_F00D, "t2_wr_top");
    run(1'b0, 32'hFC, 32'h0, "t2_rd_top");
    run(1'b0, 32'h2, 32'h0, "t2_mis");
    run(1'b0, 32'h0, 32'h0, "t2_rd_again");
    chk("t2/io0", i0.io_out, 32'd0);

    sel = 1'b1;
`ifdef MEM_RESP_MMIO_EN
    run(1'b1, 32'hFFFF_FFF4, 32'h0000_00A5, "t6_io_wr");
    run(1'b0, 32'hFFFF_FFF4, 32'h0, "t6_io_rd");
    txn(1'b0, 32'hFFFF_FFF0, 32'h0, "t6_cyc1", c1, e, tmp);
    chk("t6/cyc1_err", {31'b0, e}, 32'd0);
    repeat (6) @(negedge clk);
    txn(1'b0, 32'hFFFF_FFF0, 32'h0, "t6_cyc2", c2, e, tmp);
    chk("t6/cyc2_err", {31'b0, e}, 32'd0);
    chk("t6/cyc_delta", c2 - c1, 32'd10);
    run(1'b0, 32'hFFFF_FF00, 32'h0, "t6_other");
`else
    run(1'b1, 32'hFFFF_FFF4, 32'h0000_00A5, "t6_io_wr");
    run(1'b0, 32'hFFFF_FFF0, 32'h0, "t6_cyc_rd");
    run(1'b0, 32'hFFFF_FFF4, 32'h0, "t6_io_rd");
    chk("t6/io_const", i2.io_out, 32'd0);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
